// File: rtl/uart_pkg.sv
// Shared UART definitions: the byte type and data width used by the receiver,
// the transmitter and the receive FIFO.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef logic [UART_DATA_WIDTH-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the receive FIFO: one synchronous write port and one
// asynchronous (show-ahead) read port. Contents are not reset.
module uart_fifo_mem #(
    parameter int DEPTH_LOG = 4,
    parameter int WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [DEPTH_LOG-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [DEPTH_LOG-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side circular FIFO behind the UART receiver, with a sticky overflow flag.
// Define UART_RX_FIFO_DROP_COUNT_EN to add the saturating 8-bit drop_count output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG = 4,
    parameter int WIDTH     = UART_DATA_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DEPTH_LOG:0] count,
    output logic               full,
    output logic               overflow,
    input  logic               clear_overflow
`ifdef UART_RX_FIFO_DROP_COUNT_EN
    ,
    output logic [7:0]         drop_count
`endif
);

    localparam logic [DEPTH_LOG:0] DEPTH_CNT = (DEPTH_LOG+1)'(2**DEPTH_LOG);

    logic [DEPTH_LOG-1:0] rd_ptr;
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign pop     = out_valid && out_ready;
    assign push_ok = in_valid && (!full || pop);
    assign drop    = in_valid && full && !pop;

    assign out_valid = (count != '0);
    assign full      = (count == DEPTH_CNT);

    uart_fifo_mem #(
        .DEPTH_LOG (DEPTH_LOG),
        .WIDTH     (WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok && !reset),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (out_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A drop coinciding with clear_overflow keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= 8'd0;
        end else if (clear_overflow) begin
            drop_count <= drop ? 8'd1 : 8'd0;
        end else if (drop && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (default depth 16, width 8).
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic       clear_overflow;
`ifdef UART_RX_FIFO_DROP_COUNT_EN
    logic [7:0] drop_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    uart_rx_fifo #(
        .DEPTH_LOG (4),
        .WIDTH     (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .count          (count),
        .full           (full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
`ifdef UART_RX_FIFO_DROP_COUNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic iv, input logic [7:0] id, input logic ordy,
                                 input logic clr, input logic rst);
        in_valid       = iv;
        in_data        = id;
        out_ready      = ordy;
        clear_overflow = clr;
        reset          = rst;
        @(posedge clk);
        #1;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        reset          = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] nxt;
        logic       dp;
        logic       dq;
        int         pushes;
        int         pops;

        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        clear_overflow = 1'b0; reset = 1'b1;
        #1;

        // Reset, then idle
        applyStimulus(0, 8'h00, 0, 0, 1);
        applyStimulus(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_valid", 32'(out_valid), 0);
        checkOutput("rst_full", 32'(full), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
`ifdef UART_RX_FIFO_DROP_COUNT_EN
        checkOutput("rst_drop_count", 32'(drop_count), 0);
`endif

        // Single byte through
        applyStimulus(1, 8'hCD, 0, 0, 0);
        checkOutput("one_valid", 32'(out_valid), 1);
        checkOutput("one_data", 32'(out_data), 32'hCD);
        checkOutput("one_count", 32'(count), 1);
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("one_pop_valid", 32'(out_valid), 0);
        checkOutput("one_pop_count", 32'(count), 0);

        // Fill to 16, then one dropped byte
        for (int i = 0; i < 16; i++) applyStimulus(1, 8'(i), 0, 0, 0);
        checkOutput("fill_full", 32'(full), 1);
        checkOutput("fill_count", 32'(count), 16);
        checkOutput("fill_overflow", 32'(overflow), 0);
        applyStimulus(1, 8'h87, 0, 0, 0);
        checkOutput("drop_count_occ", 32'(count), 16);
        checkOutput("drop_overflow", 32'(overflow), 1);
        checkOutput("drop_head", 32'(out_data), 32'h00);
`ifdef UART_RX_FIFO_DROP_COUNT_EN
        checkOutput("drop_cnt1", 32'(drop_count), 1);
`endif
        for (int i = 0; i < 16; i++) begin
            checkOutput("drain_data", 32'(out_data), 32'(i));
            applyStimulus(0, 8'h00, 1, 0, 0);
        end
        checkOutput("drain_count", 32'(count), 0);
        checkOutput("drain_valid", 32'(out_valid), 0);

        applyStimulus(0, 8'h00, 0, 1, 0);
        checkOutput("clr_overflow", 32'(overflow), 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) applyStimulus(1, 8'(8'h10 + i), 0, 0, 0);
        applyStimulus(1, 8'hAA, 1, 0, 0);
        checkOutput("pp_count", 32'(count), 16);
        checkOutput("pp_overflow", 32'(overflow), 0);
        checkOutput("pp_head", 32'(out_data), 32'h11);
        for (int i = 1; i < 16; i++) begin
            checkOutput("pp_drain", 32'(out_data), 32'(8'h10 + i));
            applyStimulus(0, 8'h00, 1, 0, 0);
        end
        checkOutput("pp_last", 32'(out_data), 32'hAA);
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("pp_empty", 32'(count), 0);

        // Wrap-around with random interleaving, occupancy kept in 0..5
        nxt = 8'h40; pushes = 0; pops = 0;
        for (int it = 0; it < 400 && pops < 40; it++) begin
            dp = (pushes < 40) && (q.size() < 5) && ($urandom_range(0, 1) == 1);
            dq = (q.size() > 0) && (($urandom_range(0, 1) == 1) || q.size() == 5 || pushes == 40);
            if (!dp && !dq) begin
                if (pushes < 40 && q.size() < 5) dp = 1'b1;
                else dq = 1'b1;
            end
            if (dq) checkOutput("wrap_data", 32'(out_data), 32'(q[0]));
            checkOutput("wrap_count", 32'(count), 32'(q.size()));
            applyStimulus(dp, nxt, dq, 0, 0);
            if (dq) begin
                void'(q.pop_front());
                pops++;
            end
            if (dp) begin
                q.push_back(nxt);
                nxt = nxt + 8'd1;
                pushes++;
            end
        end
        checkOutput("wrap_pops", 32'(pops), 40);
        checkOutput("wrap_end_count", 32'(count), 0);
        checkOutput("wrap_no_drop", 32'(overflow), 0);

        // clear_overflow coinciding with a drop
        for (int i = 0; i < 16; i++) applyStimulus(1, 8'(8'h30 + i), 0, 0, 0);
        applyStimulus(1, 8'h99, 0, 1, 0);
        checkOutput("clr_drop_overflow", 32'(overflow), 1);
        checkOutput("clr_drop_count", 32'(count), 16);
`ifdef UART_RX_FIFO_DROP_COUNT_EN
        checkOutput("clr_drop_cnt", 32'(drop_count), 1);
`endif
        applyStimulus(0, 8'h00, 0, 1, 0);
        checkOutput("clr_alone_overflow", 32'(overflow), 0);
`ifdef UART_RX_FIFO_DROP_COUNT_EN
        checkOutput("clr_alone_cnt", 32'(drop_count), 0);
`endif
        applyStimulus(1, 8'h98, 0, 0, 0);
        applyStimulus(1, 8'h97, 0, 0, 0);
        checkOutput("redrop_overflow", 32'(overflow), 1);
`ifdef UART_RX_FIFO_DROP_COUNT_EN
        checkOutput("redrop_cnt", 32'(drop_count), 2);
`endif

        // Reset while holding 7 bytes
        for (int i = 0; i < 9; i++) applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("pre_rst_count", 32'(count), 7);
        checkOutput("pre_rst_head", 32'(out_data), 32'h39);
        applyStimulus(1, 8'h55, 1, 0, 1);
        checkOutput("mid_rst_count", 32'(count), 0);
        checkOutput("mid_rst_valid", 32'(out_valid), 0);
        checkOutput("mid_rst_full", 32'(full), 0);
        checkOutput("mid_rst_overflow", 32'(overflow), 0);
`ifdef UART_RX_FIFO_DROP_COUNT_EN
        checkOutput("mid_rst_cnt", 32'(drop_count), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
